// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: takes a locked board, runs clear passes with a flash
// interval before each commit, then hands back the compacted board and updates score.
module line_clear_ctrl #(
    parameter int BOARD_W      = 12,
    parameter int BOARD_H      = 20,
    parameter int FLASH_CYCLES = 8,
    parameter int MAX_LEVEL    = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BOARD_W*BOARD_H-1:0] in_board,
    output logic [BOARD_W*BOARD_H-1:0] clr_cur_board,
    input  logic [2:0]                 clr_num,
    input  logic [BOARD_W*BOARD_H-1:0] clr_new_board,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BOARD_W*BOARD_H-1:0] out_board,
    output logic [2:0]                 out_lines,
    output logic                       flash_on,
    output logic [BOARD_H-1:0]         flash_rows,
    output logic [23:0]                score,
    output logic [15:0]                lines_total,
    output logic [3:0]                 level,
    output logic [2:0]                 o_dbg_state
);

    localparam int N  = BOARD_W * BOARD_H;
    localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((FLASH_CYCLES > 0) ? FLASH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_FLASH  = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid and its payload stay stable until that edge.
    state_t             r_state;
    logic [N-1:0]       r_work;
    logic [2:0]         r_piece;
    logic [CW-1:0]      r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_flash_on;
    logic [BOARD_H-1:0] r_flash_rows;
    logic [23:0]        r_score;
    logic [15:0]        r_lines_total;
    logic [3:0]         r_level;

    logic [BOARD_H-1:0] w_full;
    logic [3:0]         w_piece_sum;
    logic [2:0]         w_piece_sat;
    logic [10:0]        w_base;
    logic [4:0]         w_mult;
    logic [15:0]        w_gain;
    logic [24:0]        w_score_sum;
    logic [16:0]        w_lines_sum;
    logic [15:0]        w_lvl_div;
    logic [3:0]         w_lvl_next;
    logic               w_accept;

    always_comb begin
        w_full = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            w_full[r] = &r_work[r*BOARD_W +: BOARD_W];
        end
    end

    always_comb begin
        w_base = 11'd0;
        case (r_piece)
            3'd0:    w_base = 11'd0;
            3'd1:    w_base = 11'd40;
            3'd2:    w_base = 11'd100;
            3'd3:    w_base = 11'd300;
            default: w_base = 11'd1200;
        endcase
    end

    assign w_piece_sum = {1'b0, r_piece} + {1'b0, clr_num};
    assign w_piece_sat = w_piece_sum[3] ? 3'd7 : w_piece_sum[2:0];
    // Score uses the level in effect before this piece's lines are added.
    assign w_mult      = {1'b0, r_level} + 5'd1;
    assign w_gain      = {5'd0, w_base} * {11'd0, w_mult};
    assign w_score_sum = {1'b0, r_score} + {9'd0, w_gain};
    assign w_lines_sum = {1'b0, r_lines_total} + {14'd0, r_piece};
    assign w_lvl_div   = r_lines_total / 16'd10;
    assign w_lvl_next  = (w_lvl_div > 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : w_lvl_div[3:0];
    assign w_accept    = (r_state == S_DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_work        <= '0;
            r_piece       <= 3'd0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_flash_on    <= 1'b0;
            r_flash_rows  <= '0;
            r_score       <= 24'd0;
            r_lines_total <= 16'd0;
            r_level       <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_board;
                        r_piece    <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (clr_num == 3'd0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (FLASH_CYCLES > 0) begin
                        r_flash_rows <= w_full;
                        r_flash_on   <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_FLASH;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_FLASH: begin
                    if (r_cnt == CNT_LAST) begin
                        r_flash_on   <= 1'b0;
                        r_flash_rows <= '0;
                        r_state      <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // Only one contiguous block goes per pass; EVAL loops for the rest.
                    r_work       <= clr_new_board;
                    r_piece      <= w_piece_sat;
                    r_flash_rows <= '0;
                    r_state      <= S_EVAL;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_flash_on  <= 1'b0;
                end
            endcase

            if (restart) begin
                r_score       <= 24'd0;
                r_lines_total <= 16'd0;
                r_level       <= 4'd0;
            end else begin
                if (w_accept) begin
                    r_score       <= w_score_sum[24] ? 24'hFF_FFFF : w_score_sum[23:0];
                    r_lines_total <= w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
                end
                r_level <= w_lvl_next;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign clr_cur_board = r_work;
    assign out_valid     = r_out_valid;
    assign out_board     = r_work;
    assign out_lines     = r_piece;
    assign flash_on      = r_flash_on;
    assign flash_rows    = r_flash_rows;
    assign score         = r_score;
    assign lines_total   = r_lines_total;
    assign level         = r_level;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: models the row-clear stage, runs directed table
// vectors, hand sequences and random pieces against a piece-level reference model.
module tb_line_clear_ctrl;

    localparam int W = 12;
    localparam int H = 20;
    localparam int F = 8;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst_n, restart, in_valid, in_ready;
    logic [N-1:0] in_board, clr_cur_board, clr_new_board, out_board;
    logic [2:0]   clr_num, out_lines, dbg_state;
    logic         out_valid, out_ready, flash_on;
    logic [H-1:0] flash_rows;
    logic [23:0]  score;
    logic [15:0]  lines_total;
    logic [3:0]   level;

    int n_vec  = 0;
    int n_fail = 0;
    int m_score = 0;
    int m_lt    = 0;
    logic [H-1:0] m_masks[$];

    line_clear_ctrl #(.BOARD_W(W), .BOARD_H(H), .FLASH_CYCLES(F), .MAX_LEVEL(15)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_board(in_board),
        .clr_cur_board(clr_cur_board), .clr_num(clr_num), .clr_new_board(clr_new_board),
        .out_valid(out_valid), .out_ready(out_ready), .out_board(out_board), .out_lines(out_lines),
        .flash_on(flash_on), .flash_rows(flash_rows),
        .score(score), .lines_total(lines_total), .level(level), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Row-clear stage: removes the lowest contiguous block of full rows (at most 4).
    function automatic bit row_full(input logic [N-1:0] b, input int r);
        return &b[r*W +: W];
    endfunction

    function automatic int lowest_full(input logic [N-1:0] b);
        for (int r = 0; r < H; r++) if (row_full(b, r)) return r;
        return -1;
    endfunction

    function automatic int run_len(input logic [N-1:0] b);
        int lo = lowest_full(b);
        int k  = 0;
        if (lo < 0) return 0;
        while (lo + k < H && k < 4 && row_full(b, lo + k)) k++;
        return k;
    endfunction

    function automatic logic [N-1:0] compact(input logic [N-1:0] b);
        logic [N-1:0] nb = '0;
        int lo = lowest_full(b);
        int k  = run_len(b);
        int j  = 0;
        for (int r = 0; r < H; r++) begin
            if (!(k > 0 && r >= lo && r < lo + k)) begin
                nb[j*W +: W] = b[r*W +: W];
                j++;
            end
        end
        return nb;
    endfunction

    function automatic logic [H-1:0] full_mask(input logic [N-1:0] b);
        logic [H-1:0] m = '0;
        for (int r = 0; r < H; r++) m[r] = row_full(b, r);
        return m;
    endfunction

    assign clr_num       = 3'(run_len(clr_cur_board));
    assign clr_new_board = compact(clr_cur_board);

    function automatic int base_pts(input int l);
        case (l)
            0: return 0;
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
    endfunction

    function automatic int lvl_of(input int lt);
        return (lt / 10 > 15) ? 15 : lt / 10;
    endfunction

    // Whole-piece reference: repeat passes until no full row remains.
    task automatic model_piece(input logic [N-1:0] b, output logic [N-1:0] fin,
                               output int lines, output int passes);
        m_masks.delete();
        lines  = 0;
        passes = 0;
        while (run_len(b) > 0) begin
            m_masks.push_back(full_mask(b));
            lines += run_len(b);
            b = compact(b);
            passes++;
        end
        fin = b;
        if (lines > 7) lines = 7;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_piece(input logic [N-1:0] b, input logic [N-1:0] exp_board,
                             input int exp_lines, input int exp_lat,
                             input int hold, input bit rs_with_ready, input bit rnd_busy);
        logic [N-1:0] fin, b0;
        logic [2:0]   l0;
        int lines, passes, guard, idx, fl_cnt, bad_rows, bad_busy, p, unstable, gain;
        bit seen;
        model_piece(b, fin, lines, passes);
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", N'(in_ready), N'(1));
        in_board = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0; fl_cnt = 0; bad_rows = 0; bad_busy = 0; p = 0; seen = 0;
        while (out_valid !== 1'b1 && idx < 300) begin
            if (flash_on === 1'b1) begin
                fl_cnt++;
                if (flash_rows !== ((p < m_masks.size()) ? m_masks[p] : '0)) bad_rows++;
                seen = 1;
            end else begin
                if (seen) p++;
                seen = 0;
                if (flash_rows !== '0) bad_rows++;
            end
            if (in_ready !== 1'b0) bad_busy++;
            if (rnd_busy) begin
                out_ready = 1'($urandom_range(0, 1));
                restart   = ($urandom_range(0, 15) == 0);
                if (restart) begin
                    m_score = 0;
                    m_lt    = 0;
                end
            end
            @(negedge clk);
            idx++;
        end
        out_ready = 1'b0;
        restart   = 1'b0;
        chk("latency", N'(idx), N'(exp_lat - 1));
        chk("flash_cycles", N'(fl_cnt), N'(passes * F));
        chk("flash_rows", N'(bad_rows), N'(0));
        chk("in_ready_busy", N'(bad_busy), N'(0));
        chk("out_board", out_board, exp_board);
        chk("out_lines", N'(out_lines), N'(exp_lines));
        b0 = out_board;
        l0 = out_lines;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_board !== b0 || out_lines !== l0 || out_valid !== 1'b1) unstable++;
        end
        if (hold > 0) chk("done_stable", N'(unstable), N'(0));
        out_ready = 1'b1;
        restart   = rs_with_ready;
        @(negedge clk);
        out_ready = 1'b0;
        restart   = 1'b0;
        if (rs_with_ready) begin
            m_score = 0;
            m_lt    = 0;
        end else begin
            gain    = base_pts(lines) * (lvl_of(m_lt) + 1);
            m_score = (m_score + gain > 24'hFF_FFFF) ? 24'hFF_FFFF : m_score + gain;
            m_lt    = (m_lt + lines > 65535) ? 65535 : m_lt + lines;
        end
        chk("out_valid_drop", N'(out_valid), N'(0));
        chk("in_ready_after", N'(in_ready), N'(1));
        chk("score", N'(score), N'(m_score));
        chk("lines_total", N'(lines_total), N'(m_lt));
        @(negedge clk);
        chk("level", N'(level), N'(lvl_of(m_lt)));
    endtask

    typedef struct {
        logic [N-1:0] board;
        logic [N-1:0] exp_board;
        int           exp_lines;
        int           exp_lat;
        int           hold;
        bit           rs;
        int           exp_score;
        int           exp_lt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [N-1:0] b, fin;
        int lines, passes, top, sel;

        for (int i = 0; i < 5; i++) begin
            tbl[i].board = '0; tbl[i].exp_board = '0; tbl[i].hold = 0; tbl[i].rs = 0;
        end
        tbl[0].exp_lines = 0; tbl[0].exp_lat = 2;  tbl[0].exp_score = 0;    tbl[0].exp_lt = 0;
        tbl[1].board[0 +: W] = '1;
        tbl[1].exp_lines = 1; tbl[1].exp_lat = 12; tbl[1].exp_score = 40;   tbl[1].exp_lt = 1;
        tbl[2].board[0 +: 4*W] = '1;
        tbl[2].board[4*W +: W] = 12'h001;
        tbl[2].exp_board[0 +: W] = 12'h001;
        tbl[2].exp_lines = 4; tbl[2].exp_lat = 12; tbl[2].exp_score = 1240; tbl[2].exp_lt = 5;
        tbl[3].board[0 +: W] = '1;
        tbl[3].board[W +: W] = 12'h0F0;
        tbl[3].board[2*W +: W] = '1;
        tbl[3].exp_board[0 +: W] = 12'h0F0;
        tbl[3].exp_lines = 2; tbl[3].exp_lat = 22; tbl[3].exp_score = 1340; tbl[3].exp_lt = 7;
        tbl[4].board[0 +: 2*W] = '1;
        tbl[4].hold = 5; tbl[4].rs = 1;
        tbl[4].exp_lines = 2; tbl[4].exp_lat = 12; tbl[4].exp_score = 0;    tbl[4].exp_lt = 0;

        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_board = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", N'(out_valid), N'(0));
        chk("rst_flash_on", N'(flash_on), N'(0));
        chk("rst_flash_rows", N'(flash_rows), N'(0));
        chk("rst_score", N'(score), N'(0));
        chk("rst_lines_total", N'(lines_total), N'(0));
        chk("rst_level", N'(level), N'(0));
        chk("rst_board", clr_cur_board, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", N'(in_ready), N'(1));

        for (int i = 0; i < 5; i++) begin
            run_piece(tbl[i].board, tbl[i].exp_board, tbl[i].exp_lines, tbl[i].exp_lat,
                      tbl[i].hold, tbl[i].rs, 1'b0);
            chk("tbl_score", N'(score), N'(tbl[i].exp_score));
            chk("tbl_lines_total", N'(lines_total), N'(tbl[i].exp_lt));
        end

        // Ten single-line pieces reach level 1, then a double scores 2*100.
        b = '0;
        b[0 +: W] = '1;
        for (int i = 0; i < 10; i++) run_piece(b, '0, 1, 12, 0, 1'b0, 1'b0);
        chk("lvl_seq_score", N'(score), N'(400));
        chk("lvl_seq_level", N'(level), N'(1));
        b[W +: W] = '1;
        run_piece(b, '0, 2, 12, 0, 1'b0, 1'b0);
        chk("lvl_seq_score2", N'(score), N'(600));
        chk("lvl_seq_lines", N'(lines_total), N'(12));

        for (int t = 0; t < 40; t++) begin
            b   = '0;
            top = $urandom_range(4, H);
            for (int r = 0; r < top; r++) begin
                sel = $urandom_range(0, 5);
                b[r*W +: W] = (sel < 2) ? {W{1'b1}} : W'($urandom);
            end
            model_piece(b, fin, lines, passes);
            run_piece(b, fin, lines, 2 + passes * (2 + F), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0), 1'b1);
        end

        // Reset in the middle of a flash interval abandons the piece.
        b = '0;
        b[0 +: W] = '1;
        @(negedge clk);
        in_board = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_flash", N'(flash_on), N'(1));
        rst_n = 1'b0;
        @(negedge clk);
        m_score = 0;
        m_lt    = 0;
        chk("midrst_out_valid", N'(out_valid), N'(0));
        chk("midrst_flash_on", N'(flash_on), N'(0));
        chk("midrst_flash_rows", N'(flash_rows), N'(0));
        chk("midrst_score", N'(score), N'(m_score));
        chk("midrst_lines_total", N'(lines_total), N'(m_lt));
        chk("midrst_level", N'(level), N'(0));
        chk("midrst_board", out_board, '0);
        chk("midrst_out_lines", N'(out_lines), N'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", N'(in_ready), N'(1));
        out_ready = 1'b1;
        sel = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) sel++;
        end
        out_ready = 1'b0;
        chk("midrst_no_emit", N'(sel), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Sequential controller directly downstream of piece lock, wrapped around the combinational row-clear stage.
- Accepts a freshly locked board and drives it into the row-clear stage.
- Repeats clear passes until no full rows remain, holding a flash interval before each commit.
- Returns the compacted board through a valid/ready handshake and maintains score, total lines and level.

Parameters:
- BOARD_W, 12, cells per row.
- BOARD_H, 20, rows. Row r occupies bits [r*BOARD_W +: BOARD_W].
- FLASH_CYCLES, 8, cycles the cleared rows are flagged before commit. 0 disables flashing.
- MAX_LEVEL, 15, level saturation value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- restart  in  1  synchronous clear of score, lines_total and level only.
- in_valid  in  1  locked board available.
- in_ready  out  1  controller can accept a board.
- in_board  in  BOARD_W*BOARD_H  locked board.
- clr_cur_board  out  BOARD_W*BOARD_H  drives the clear stage input; always equal to the working register.
- clr_num  in  3  clear stage: number of rows removed this pass.
- clr_new_board  in  BOARD_W*BOARD_H  clear stage: compacted board.
- out_valid  out  1  result board available.
- out_ready  in  1  consumer accepts the result.
- out_board  out  BOARD_W*BOARD_H  final board.
- out_lines  out  3  rows cleared for this piece, summed over passes.
- flash_on  out  1  high during FLASH.
- flash_rows  out  BOARD_H  mask of full rows being cleared; 0 outside FLASH.
- score  out  24  accumulated score.
- lines_total  out  16  accumulated cleared rows.
- level  out  4  min(lines_total/10, MAX_LEVEL).

Behaviour:
- Reset (rst_n=0 at posedge):
  - State IDLE; working board 0; piece_lines 0.
  - score 0, lines_total 0, level 0.
  - out_valid 0, flash_on 0, flash_rows 0.
  - in_ready 1 one cycle after reset deasserts.
  - Reset mid-operation abandons the piece; nothing is emitted.
- States: IDLE, EVAL, FLASH, COMMIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_board into the working register, clear piece_lines, go to EVAL.
  - in_ready is 0 in every other state.
- EVAL (1 cycle):
  - clr_num==0 -> DONE.
  - Otherwise latch full-row mask (row r bit set iff all BOARD_W bits are 1) into flash_rows.
  - FLASH_CYCLES>0 -> FLASH with counter 0; else -> COMMIT.
- FLASH:
  - flash_on=1; flash_rows holds the latched mask.
  - Counter increments each cycle; after FLASH_CYCLES cycles -> COMMIT.
- COMMIT (1 cycle):
  - working <= clr_new_board.
  - piece_lines <= sat7(piece_lines + clr_num).
  - flash_rows <= 0; -> EVAL.
  - Non-contiguous full rows are handled by further passes.
- DONE:
  - out_valid=1; out_board=working; out_lines=piece_lines. Held stable until out_ready.
  - On out_valid&&out_ready:
    - score += base(piece_lines)*(level+1), with level taken pre-update.
    - lines_total += piece_lines.
    - -> IDLE.
  - base: 0->0, 1->40, 2->100, 3->300, >=4->1200.
  - score and lines_total saturate at all-ones.
  - level is a registered function of lines_total and updates one cycle after lines_total.
- Latency: in handshake at cycle T.
  - No full rows: out_valid at T+2.
  - One pass: out_valid at T+4+FLASH_CYCLES.
  - Each extra pass adds 2+FLASH_CYCLES.
- restart:
  - Clears score, lines_total and level in any state; FSM is unaffected.
  - Coincident with a DONE handshake, restart wins: stats end at 0.
- out_ready high while not in DONE has no effect.
- in_valid while busy is ignored; the upstream stage holds it.

Test Plan:
- Empty board in, out_ready=1 -> out_valid at T+2, out_board=0, out_lines=0, score stays 0, flash_on never asserted.
- Row 0 full, other rows empty, FLASH_CYCLES=8 -> flash_rows=20'h00001 for exactly 8 cycles, then out_board=0, out_lines=1, score=40, lines_total=1.
- Rows 0-3 full, row 4 = 12'h001 -> single pass, out_lines=4, board row 0=12'h001, score=1200.
- Rows 0 and 2 full, row 1 = 12'h0F0 -> two flash passes, out_lines=2, row 0=12'h0F0, score=100.
- Preload 10 single-line pieces (lines_total=10, level=1), then clear 2 rows -> score increments by 200, lines_total=12.
- out_ready held low 5 cycles in DONE -> out_board and out_lines stable. Then assert restart together with out_ready -> score=0, lines_total=0, next in_ready=1.
- rst_n low during FLASH -> all outputs 0, in_ready=1 after release, no out_valid.
